// File: rtl/alu_operand_stage_pkg.sv
// Shared constants for the ALU issue stage: opcodes, instruction field positions, widths.
// Also provides the compare-op decode that separates CB-updating ops from register-writing ops.
package alu_operand_stage_pkg;

   localparam int DATA_W     = 8;
   localparam int REG_ADDR_W = 3;
   localparam int NUM_REGS   = 8;
   localparam int OPC_W      = 3;
   localparam int INSTR_W    = 9;

   localparam int OPC_HI = 8;
   localparam int OPC_LO = 6;
   localparam int RS_HI  = 5;
   localparam int RS_LO  = 3;
   localparam int RT_HI  = 2;
   localparam int RT_LO  = 0;

   localparam logic [OPC_W-1:0] OP_AND = 3'b000;
   localparam logic [OPC_W-1:0] OP_ADD = 3'b001;
   localparam logic [OPC_W-1:0] OP_SLL = 3'b010;
   localparam logic [OPC_W-1:0] OP_SRL = 3'b011;
   localparam logic [OPC_W-1:0] OP_SUB = 3'b100;
   localparam logic [OPC_W-1:0] OP_SLT = 3'b101;
   localparam logic [OPC_W-1:0] OP_ABS = 3'b110;
   localparam logic [OPC_W-1:0] OP_SEQ = 3'b111;

   // Compare ops write only the condition bit, never a register.
   function automatic logic is_cmp_op(input logic [OPC_W-1:0] opc);
      return (opc == OP_SLT) || (opc == OP_SEQ);
   endfunction

endpackage

// File: rtl/alu_operand_stage_regfile.sv
// Architectural 8x8 register file: two combinational read ports, one write port, async reset to zero.
// Reads see a same-cycle write (bypass); no backpressure, writes land on every strobed edge.
module alu_regfile #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 3
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] rd_a_addr,
   output logic [DATA_W-1:0] rd_a_data,
   input  logic [ADDR_W-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_b_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data
);

   logic [DATA_W-1:0] mem [NUM_REGS];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // Each port bypasses independently, so rs == rt both pick up the in-flight write.
   assign rd_a_data = (wr_en && (wr_addr == rd_a_addr)) ? wr_data : mem[rd_a_addr];
   assign rd_b_data = (wr_en && (wr_addr == rd_b_addr)) ? wr_data : mem[rd_b_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// Issue stage ahead of the 8-bit ALU: decodes, reads operands, holds one op in a registered slot.
// Latency 1 cycle instr->op_valid_o; instr_ready_o = !op_valid_o || op_ready_i (pass-through on consume).
module alu_operand_stage #(
   parameter int NUM_REGS = 8,
   parameter int DATA_W   = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              instr_valid_i,
   input  logic [8:0]        instr_i,
   output logic              instr_ready_o,
   output logic [2:0]        opcode_o,
   output logic [DATA_W-1:0] rs_o,
   output logic [DATA_W-1:0] rt_o,
   output logic [2:0]        dest_o,
   output logic              wb_req_o,
   output logic              cb_req_o,
   output logic              op_valid_o,
   input  logic              op_ready_i,
   input  logic              wb_en_i,
   input  logic [2:0]        wb_addr_i,
   input  logic [DATA_W-1:0] wb_data_i,
   input  logic              cb_en_i,
   input  logic              cb_i,
   output logic              cb_o
);

   import alu_operand_stage_pkg::*;

   logic                  accept;
   logic [OPC_W-1:0]      dec_opc;
   logic [REG_ADDR_W-1:0] dec_rs;
   logic [REG_ADDR_W-1:0] dec_rt;
   logic [DATA_W-1:0]     rd_rs_dat;
   logic [DATA_W-1:0]     rd_rt_dat;

   assign dec_opc = instr_i[OPC_HI:OPC_LO];
   assign dec_rs  = instr_i[RS_HI:RS_LO];
   assign dec_rt  = instr_i[RT_HI:RT_LO];

   assign instr_ready_o = !op_valid_o || op_ready_i;
   assign accept        = instr_valid_i && instr_ready_o;

   alu_regfile #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .ADDR_W   (REG_ADDR_W)
   ) u_regfile (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rd_a_addr (dec_rs),
      .rd_a_data (rd_rs_dat),
      .rd_b_addr (dec_rt),
      .rd_b_data (rd_rt_dat),
      .wr_en     (wb_en_i),
      .wr_addr   (wb_addr_i),
      .wr_data   (wb_data_i)
   );

   // Operands are captured once at accept; a stalled op never re-reads the file.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         op_valid_o <= 1'b0;
         opcode_o   <= '0;
         rs_o       <= '0;
         rt_o       <= '0;
         dest_o     <= '0;
         wb_req_o   <= 1'b0;
         cb_req_o   <= 1'b0;
      end else if (accept) begin
         op_valid_o <= 1'b1;
         opcode_o   <= dec_opc;
         rs_o       <= rd_rs_dat;
         rt_o       <= rd_rt_dat;
         dest_o     <= dec_rs;
         wb_req_o   <= !is_cmp_op(dec_opc);
         cb_req_o   <= is_cmp_op(dec_opc);
      end else if (op_ready_i) begin
         op_valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cb_o <= 1'b0;
      end else if (cb_en_i) begin
         cb_o <= cb_i;
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: stimulus pushes expected ops computed from a register-array model,
// a negedge monitor compares the output slot against the queue head and pops on consume.
module tb_alu_operand_stage;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic       instr_valid_i = 1'b0;
   logic [8:0] instr_i = '0;
   logic       instr_ready_o;
   logic [2:0] opcode_o;
   logic [7:0] rs_o;
   logic [7:0] rt_o;
   logic [2:0] dest_o;
   logic       wb_req_o;
   logic       cb_req_o;
   logic       op_valid_o;
   logic       op_ready_i = 1'b1;
   logic       wb_en_i = 1'b0;
   logic [2:0] wb_addr_i = '0;
   logic [7:0] wb_data_i = '0;
   logic       cb_en_i = 1'b0;
   logic       cb_i = 1'b0;
   logic       cb_o;

   alu_operand_stage #(.NUM_REGS(8), .DATA_W(8)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .instr_valid_i (instr_valid_i),
      .instr_i       (instr_i),
      .instr_ready_o (instr_ready_o),
      .opcode_o      (opcode_o),
      .rs_o          (rs_o),
      .rt_o          (rt_o),
      .dest_o        (dest_o),
      .wb_req_o      (wb_req_o),
      .cb_req_o      (cb_req_o),
      .op_valid_o    (op_valid_o),
      .op_ready_i    (op_ready_i),
      .wb_en_i       (wb_en_i),
      .wb_addr_i     (wb_addr_i),
      .wb_data_i     (wb_data_i),
      .cb_en_i       (cb_en_i),
      .cb_i          (cb_i),
      .cb_o          (cb_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [2:0] opc;
      logic [7:0] a;
      logic [7:0] b;
      logic [2:0] dest;
      logic       wb;
      logic       cb;
   } exp_t;

   exp_t       q[$];
   logic [7:0] m_regs [8];
   logic       m_cb = 1'b0;
   int         acc_now = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [2:0] addr, input logic wen,
                                             input logic [2:0] wa, input logic [7:0] wd);
      if (wen && wa == addr) return wd;
      return m_regs[addr];
   endfunction

   // One clock: drive at posedge+1, evaluate handshake and update the model at posedge+4.
   task automatic cycle(input logic vld, input logic [8:0] ins, input logic ordy,
                        input logic wen, input logic [2:0] wa, input logic [7:0] wd,
                        input logic cen, input logic cbv);
      logic exp_rdy;
      exp_t e;
      @(posedge clk_i);
      #1;
      instr_valid_i = vld; instr_i = ins; op_ready_i = ordy;
      wb_en_i = wen; wb_addr_i = wa; wb_data_i = wd; cb_en_i = cen; cb_i = cbv;
      #3;
      exp_rdy = (q.size() == 0) || ordy;
      check("instr_ready", instr_ready_o, exp_rdy);
      check("cb", cb_o, m_cb);
      acc_now = 0;
      if (vld && exp_rdy) begin
         e.opc  = ins[8:6];
         e.dest = ins[5:3];
         e.a    = model_read(ins[5:3], wen, wa, wd);
         e.b    = model_read(ins[2:0], wen, wa, wd);
         e.cb   = (ins[8:6] == 3'd5) || (ins[8:6] == 3'd7);
         e.wb   = !e.cb;
         q.push_back(e);
         acc_now = 1;
      end
      if (wen) m_regs[wa] = wd;
      if (cen) m_cb = cbv;
   endtask

   task automatic idle();
      cycle(1'b0, 9'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
   endtask

   always @(negedge clk_i) begin
      logic exp_v;
      exp_v = (q.size() > acc_now);
      check("op_valid", op_valid_o, exp_v);
      if (exp_v && op_valid_o) begin
         check("opcode", opcode_o, q[0].opc);
         check("rs", rs_o, q[0].a);
         check("rt", rt_o, q[0].b);
         check("dest", dest_o, q[0].dest);
         check("wb_req", wb_req_o, q[0].wb);
         check("cb_req", cb_req_o, q[0].cb);
         if (op_ready_i) void'(q.pop_front());
      end
   end

   initial begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      #3;
      check("rst op_valid", op_valid_o, 1'b0);
      check("rst cb", cb_o, 1'b0);
      check("rst rs", rs_o, 8'h00);
      check("rst opcode", opcode_o, 3'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // add r2,r3 from reset state
      cycle(1'b1, 9'b001_010_011, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
      idle();
      check("t1 opcode", opcode_o, 3'b001);
      check("t1 rs", rs_o, 8'h00);
      check("t1 rt", rt_o, 8'h00);
      check("t1 dest", dest_o, 3'd2);
      check("t1 wb_req", wb_req_o, 1'b1);
      check("t1 cb_req", cb_req_o, 1'b0);

      cycle(1'b0, 9'd0, 1'b1, 1'b1, 3'd2, 8'h05, 1'b0, 1'b0);
      cycle(1'b0, 9'd0, 1'b1, 1'b1, 3'd3, 8'hFA, 1'b0, 1'b0);
      cycle(1'b1, 9'b100_010_011, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
      idle();
      check("t2 rs", rs_o, 8'h05);
      check("t2 rt", rt_o, 8'hFA);
      check("t2 dest", dest_o, 3'd2);

      // same-cycle bypass on both ports
      cycle(1'b1, 9'b111_111_111, 1'b1, 1'b1, 3'd7, 8'h3C, 1'b0, 1'b0);
      idle();
      check("t3 rs", rs_o, 8'h3C);
      check("t3 rt", rt_o, 8'h3C);
      check("t3 cb_req", cb_req_o, 1'b1);
      check("t3 wb_req", wb_req_o, 1'b0);

      // stall: held op frozen, waiting instruction rejected, writes still land
      cycle(1'b1, 9'b010_001_010, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 9'b011_011_100, 1'b0, 1'b1, 3'd4, 8'h40 + 8'(i), 1'b0, 1'b0);
         check("stall ready", instr_ready_o, 1'b0);
         check("stall opcode", opcode_o, 3'b010);
      end
      cycle(1'b1, 9'b011_011_100, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 9'($urandom), 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
         check("b2b ready", instr_ready_o, 1'b1);
      end
      idle();

      // CB update then hold
      cycle(1'b0, 9'd0, 1'b1, 1'b0, 3'd0, 8'd0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) idle();
      check("cb hold", cb_o, 1'b1);

      for (int i = 0; i < 400; i++) begin
         cycle(($urandom_range(0, 3) != 0), 9'($urandom), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 1) == 1), 3'($urandom), 8'($urandom),
               ($urandom_range(0, 3) == 0), 1'($urandom));
      end
      idle();
      idle();

      // async reset with a held op and r4 = 0x77
      cycle(1'b0, 9'd0, 1'b1, 1'b1, 3'd4, 8'h77, 1'b1, 1'b1);
      cycle(1'b1, 9'b000_100_100, 1'b0, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
      @(posedge clk_i);
      #1;
      check("pre-rst op_valid", op_valid_o, 1'b1);
      instr_valid_i = 1'b0; wb_en_i = 1'b0; cb_en_i = 1'b0;
      #1;
      rst_i = 1'b1;
      #1;
      check("mid rst op_valid", op_valid_o, 1'b0);
      check("mid rst cb", cb_o, 1'b0);
      q.delete();
      acc_now = 0;
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_cb = 1'b0;
      @(negedge clk_i);
      #1;
      rst_i = 1'b0;
      cycle(1'b1, 9'b001_100_100, 1'b1, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
      idle();
      check("post rst r4", rs_o, 8'h00);
      check("post rst r4 rt", rt_o, 8'h00);
      idle();
      idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
